// File: rtl/rotation_theta_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : rotation_theta_tracker
//  Description : Turns the raw IR once-per-revolution trip into a slice index.
//                It measures each revolution in clock cycles, splits that into
//                ROTATIONAL_RES equal slices, and steps dtheta once per slice
//                over the following revolution.
//  Revision    : 1.0  initial release
// ============================================================================
module rotation_theta_tracker #(
    parameter int ROTATIONAL_RES = 256,
    parameter int PERIOD_WIDTH   = 24,
    parameter int MIN_GAP_CYCLES = 12000
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              ir_tripped,
    output logic [$clog2(ROTATIONAL_RES)-1:0] dtheta,
    output logic                              slice_strobe,
    output logic                              locked,
    output logic [PERIOD_WIDTH-1:0]           period,
    output logic                              overrun
);

    localparam int                     c_theta_w   = $clog2(ROTATIONAL_RES);
    localparam logic [c_theta_w-1:0]   c_theta_max = c_theta_w'(ROTATIONAL_RES - 1);
    localparam logic [c_theta_w-1:0]   c_theta_one = c_theta_w'(1);
    localparam logic [PERIOD_WIDTH-1:0] c_gap_max  = '1;
    localparam logic [PERIOD_WIDTH-1:0] c_one      = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] c_min_gap  = PERIOD_WIDTH'(MIN_GAP_CYCLES);

    typedef enum logic [1:0] {
        c_unlocked = 2'd0,
        c_acquire  = 2'd1,
        c_locked   = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_ir_meta;
    logic                    r_ir_sync;
    logic                    r_ir_prev;
    logic [PERIOD_WIDTH-1:0] r_gap_cnt;
    logic [PERIOD_WIDTH-1:0] r_slice_cnt;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [c_theta_w-1:0]    r_dtheta;
    logic                    r_slice_strobe;
    logic                    r_locked;
    logic                    r_overrun;

    logic                    w_ir_rise;
    logic                    w_edge_ok;
    logic [PERIOD_WIDTH-1:0] w_gap_next;
    logic [PERIOD_WIDTH-1:0] w_new_slice_len;
    logic [PERIOD_WIDTH-1:0] w_slice_len;
    logic                    w_new_slice_zero;
    logic                    w_slice_last;
    logic                    w_gap_sat;
    logic                    w_gap_hit;

    // Two-flop synchroniser for the asynchronous sensor plus an edge-history flop
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_ir_meta <= 1'b0;
            r_ir_sync <= 1'b0;
            r_ir_prev <= 1'b0;
        end else begin
            r_ir_meta <= ir_tripped;
            r_ir_sync <= r_ir_meta;
            r_ir_prev <= r_ir_sync;
        end
    end

    // Edge qualification: bounce filter is bypassed until the first edge is taken
    assign w_ir_rise = r_ir_sync & ~r_ir_prev;
    assign w_edge_ok = w_ir_rise & ((r_gap_cnt >= c_min_gap) | (r_state == c_unlocked));

    // The count at the edge cycle excludes that cycle, hence the +1 for the period
    assign w_gap_next       = r_gap_cnt + c_one;
    assign w_new_slice_len  = w_gap_next >> c_theta_w;
    assign w_new_slice_zero = (w_new_slice_len == '0);
    assign w_slice_len      = r_period >> c_theta_w;
    assign w_slice_last     = (r_slice_cnt == (w_slice_len - c_one));
    assign w_gap_sat        = (r_gap_cnt == c_gap_max);
    assign w_gap_hit        = (r_gap_cnt == (c_gap_max - c_one));

    // Tracker FSM: gap counter, period capture, slice stepping and all outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state        <= c_unlocked;
            r_gap_cnt      <= '0;
            r_slice_cnt    <= '0;
            r_period       <= '0;
            r_dtheta       <= '0;
            r_slice_strobe <= 1'b0;
            r_locked       <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_slice_strobe <= 1'b0;
            r_overrun      <= 1'b0;

            if (w_edge_ok) begin
                r_gap_cnt <= '0;
            end else if (!w_gap_sat) begin
                r_gap_cnt <= w_gap_next;
            end

            if (w_edge_ok) begin
                // An accepted edge takes priority over slice steps and overrun
                if (r_state == c_unlocked) begin
                    r_state <= c_acquire;
                end else begin
                    r_period <= w_gap_next;
                    if (w_new_slice_zero) begin
                        // Revolution too short to slice: fall back to acquiring
                        r_state  <= c_acquire;
                        r_locked <= 1'b0;
                        if (r_state == c_locked) begin
                            r_dtheta       <= '0;
                            r_slice_cnt    <= '0;
                            r_slice_strobe <= 1'b1;
                        end
                    end else begin
                        r_state        <= c_locked;
                        r_locked       <= 1'b1;
                        r_dtheta       <= '0;
                        r_slice_cnt    <= '0;
                        r_slice_strobe <= 1'b1;
                    end
                end
            end else if (w_gap_hit) begin
                // Counter is about to saturate: the rotor has stopped or the sensor died
                r_overrun   <= 1'b1;
                r_state     <= c_unlocked;
                r_locked    <= 1'b0;
                r_dtheta    <= '0;
                r_slice_cnt <= '0;
            end else if (r_state == c_locked) begin
                if (w_slice_last) begin
                    r_slice_cnt <= '0;
                    // Hold at the last slice if the revolution runs long; never wrap
                    if (r_dtheta != c_theta_max) begin
                        r_dtheta       <= r_dtheta + c_theta_one;
                        r_slice_strobe <= 1'b1;
                    end
                end else begin
                    r_slice_cnt <= r_slice_cnt + c_one;
                end
            end
        end
    end

    assign dtheta       = r_dtheta;
    assign slice_strobe = r_slice_strobe;
    assign locked       = r_locked;
    assign period       = r_period;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: doc/rotation_theta_tracker.md
Name: rotation_theta_tracker

Overview:
- Converts the raw IR once-per-revolution trip signal into a slice index (dtheta) for frame_manager, which sits directly downstream.
- Measures the cycle count of each revolution and divides it into ROTATIONAL_RES equal slices.
- Over the next revolution, advances dtheta once per slice and pulses slice_strobe so downstream stages can load the next column.
- Reports lock status; dtheta is only meaningful while locked.

Parameters:
- ROTATIONAL_RES, 256: slices per revolution; must be a power of two.
- PERIOD_WIDTH, 24: width of the revolution cycle counter.
- MIN_GAP_CYCLES, 12000: IR rising edges closer than this to the previous accepted edge are rejected as bounce (1 ms at 12 MHz).

Ports:
- clk_in  input  1  system clock (12 MHz sysclk)
- rst_in  input  1  synchronous, active-high reset
- ir_tripped  input  1  raw asynchronous IR sensor output
- dtheta  output  $clog2(ROTATIONAL_RES)  current slice index
- slice_strobe  output  1  one-cycle pulse on every dtheta update, including the reset to 0 at an accepted edge
- locked  output  1  high while the period estimate is valid
- period  output  PERIOD_WIDTH  last measured revolution length in cycles
- overrun  output  1  one-cycle pulse when the cycle counter saturates

Behaviour:
- Reset values: all outputs 0, state UNLOCKED, all counters 0.
- Input conditioning:
  - ir_tripped passes through a 2-FF synchroniser, then a rising-edge detector.
  - An edge is accepted only if gap_cnt >= MIN_GAP_CYCLES, or the state is UNLOCKED.
  - Rejected edges have no effect at all.
- Counters:
  - gap_cnt (PERIOD_WIDTH) increments every cycle and clears to 0 on an accepted edge.
  - gap_cnt saturates at all-ones. On reaching saturation, overrun pulses once, state goes to UNLOCKED, and locked drops the same cycle.
- Slice length: slice_len = period >> $clog2(ROTATIONAL_RES), i.e. the floor. The remainder is discarded; the last slice absorbs the residue.
- State UNLOCKED:
  - locked = 0, dtheta held at 0.
  - On an accepted edge: go to ACQUIRE, clear gap_cnt.
- State ACQUIRE:
  - On an accepted edge: period <= gap_cnt + 1 (the full count including the edge cycle).
  - If the new slice_len is 0 (period < ROTATIONAL_RES), stay in ACQUIRE.
  - Otherwise go to LOCKED: dtheta <= 0, slice_cnt <= 0, slice_strobe pulses.
- State LOCKED:
  - slice_cnt increments every cycle.
  - When slice_cnt == slice_len-1: slice_cnt <= 0; dtheta increments, saturating at ROTATIONAL_RES-1 (it never wraps to 0 on its own); slice_strobe pulses only if dtheta actually changed.
  - On an accepted edge: period updates, dtheta <= 0, slice_cnt <= 0, slice_strobe pulses.
  - If the new slice_len is 0, go to ACQUIRE and drop locked.
- Latency: 3 clk_in cycles from the ir_tripped rising edge to dtheta = 0 / slice_strobe (2 sync + 1 register).
- Simultaneous events: an accepted edge on the same cycle as a slice boundary → the edge wins; dtheta = 0 and a single slice_strobe.
- Overrun and edge on the same cycle → the edge wins; there is no overrun pulse.
- Reset mid-revolution returns to UNLOCKED; the first post-reset edge only begins acquisition.
- period holds its last value while unlocked (cleared only by reset).

Test Plan:
- Reset, then IR edges every 25600 cycles → first edge gives ACQUIRE, locked=0. Second edge gives locked=1 and period=25600 (slice_len=100). dtheta increments every 100 cycles, reaching 255 just before the third edge, then returns to 0 with a single strobe.
- Locked at period 25600, inject a second IR pulse 500 cycles after an edge → rejected; dtheta continues 0..5 undisturbed; period unchanged.
- Locked at 25600, then the next edge is delayed to 30000 → dtheta saturates at 255 for the final 4400 cycles with no extra strobes. New period=30000, slice_len=117.
- Stop IR edges after lock with PERIOD_WIDTH overridden to 16 → overrun pulses once at gap_cnt=65535; locked falls that cycle; dtheta=0.
- Edges every 200 cycles with MIN_GAP_CYCLES=100 → slice_len=0; the block stays in ACQUIRE, locked never rises, period=200.
- Assert rst_in mid-revolution while locked at dtheta=130 → the next cycle shows dtheta=0, locked=0, period=0. Two further edges 25600 apart are needed to relock.
